adventure_player: RTL and testbench

Scripted initiator for the adventure-game core: stores a route of up to ROUTE_LEN moves, then replays it as one-cycle, one-hot north/south/west/east pulses into the game. It watches the game's win/die flags between moves and reports how the run ended. It sits beside the game core on the same clock and reset, as an autonomous test/demo driver in place of the player buttons.

---
 rtl/adventure_cmd_pkg.sv | 6 +
 rtl/adventure_player_route_buffer.sv | 20 ++
 rtl/adventure_player.sv | 115 +++++++++++
 tb/tb_adventure_player.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/adventure_cmd_pkg.sv
// adventure_cmd: shared move, result and player-state encodings for the adventure core
package adventure_cmd;
    typedef enum logic [1:0] {D_NORTH, D_SOUTH, D_WEST, D_EAST} dir_type;
    typedef enum logic [1:0] {RES_NONE, RES_WIN, RES_DIE, RES_EXHAUSTED} result_type;
    typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_WAIT, P_DONE} player_state_type;
endpackage

// File: rtl/adventure_player_route_buffer.sv
// route_buffer: unreset register array of moves with one write port and a combinational read
module route_buffer
    import adventure_cmd::*;
#(
    parameter int ROUTE_LEN = 8,
    parameter int IW = 3
)(
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  dir_type       wdata,
    input  logic [IW-1:0] rd_idx,
    output dir_type       rdata
);
    dir_type mem [ROUTE_LEN];
    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wdata;
    end
    assign rdata = mem[rd_idx];
endmodule

// File: rtl/adventure_player.sv
// adventure_player: stores a route of moves and replays it as one-hot pulses, reporting win/die/exhausted
module adventure_player
    import adventure_cmd::*;
#(
    parameter int ROUTE_LEN = 8,
    parameter int GAP = 1,
    localparam int CW = $clog2(ROUTE_LEN + 1)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  dir_type       load_dir,
    input  logic          clear,
    input  logic          start,
    input  logic          win,
    input  logic          die,
    output logic          north,
    output logic          south,
    output logic          west,
    output logic          east,
    output logic          busy,
    output logic          done,
    output result_type    result,
    output logic [CW-1:0] route_len,
    output logic [CW-1:0] step_count,
    output logic          full
);
    localparam int IW = (ROUTE_LEN > 1) ? $clog2(ROUTE_LEN) : 1;
    localparam int GW = $clog2(GAP + 1);
    player_state_type state, state_nxt;
    logic [CW-1:0] rd_ptr, rd_nxt, step_nxt, len_nxt;
    logic [GW-1:0] gap, gap_nxt;
    result_type res_nxt;
    dir_type cur_dir;
    logic we;
    route_buffer #(.ROUTE_LEN(ROUTE_LEN), .IW(IW)) u_route (
        .clk   (clk),
        .we    (we),
        .wr_idx(route_len[IW-1:0]),
        .wdata (load_dir),
        .rd_idx(rd_ptr[IW-1:0]),
        .rdata (cur_dir)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= P_IDLE;
            rd_ptr     <= '0;
            step_count <= '0;
            result     <= RES_NONE;
            gap        <= '0;
            route_len  <= '0;
        end else begin
            state      <= state_nxt;
            rd_ptr     <= rd_nxt;
            step_count <= step_nxt;
            result     <= res_nxt;
            gap        <= gap_nxt;
            route_len  <= len_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        rd_nxt    = rd_ptr;
        step_nxt  = step_count;
        res_nxt   = result;
        gap_nxt   = gap;
        len_nxt   = route_len;
        we        = 1'b0;
        case (state)
            P_IDLE, P_DONE: begin
                if (clear) begin
                    len_nxt = '0;
                    if (state == P_DONE) begin
                        state_nxt = P_IDLE;
                        res_nxt   = RES_NONE;
                        step_nxt  = '0;
                    end
                end else if (start) begin
                    rd_nxt    = '0;
                    step_nxt  = '0;
                    res_nxt   = (route_len == '0) ? RES_EXHAUSTED : RES_NONE;
                    state_nxt = (route_len == '0) ? P_DONE : P_ISSUE;
                end else if (load_en && !full) begin
                    we      = 1'b1;
                    len_nxt = route_len + CW'(1);
                end
            end
            P_ISSUE: begin
                rd_nxt    = rd_ptr + CW'(1);
                step_nxt  = step_count + CW'(1);
                gap_nxt   = GW'(GAP);
                state_nxt = P_WAIT;
            end
            P_WAIT: begin
                if (die || win) begin
                    state_nxt = P_DONE;
                    res_nxt   = die ? RES_DIE : RES_WIN;
                end else if (gap == GW'(1)) begin
                    state_nxt = (rd_ptr == route_len) ? P_DONE : P_ISSUE;
                    res_nxt   = (rd_ptr == route_len) ? RES_EXHAUSTED : RES_NONE;
                end else begin
                    gap_nxt = gap - GW'(1);
                end
            end
            default: state_nxt = P_IDLE;
        endcase
    end
    assign north = state == P_ISSUE && cur_dir == D_NORTH;
    assign south = state == P_ISSUE && cur_dir == D_SOUTH;
    assign west  = state == P_ISSUE && cur_dir == D_WEST;
    assign east  = state == P_ISSUE && cur_dir == D_EAST;
    assign busy  = state == P_ISSUE || state == P_WAIT;
    assign done  = state == P_DONE;
    assign full  = route_len == CW'(ROUTE_LEN);
endmodule

// File: tb/tb_adventure_player.sv
// tb_adventure_player: randomized replay runs checked against a schedule-level model of the player
module tb_adventure_player;
    import adventure_cmd::*;
    localparam int ROUTE_LEN = 8;
    localparam int GAP = 1;
    localparam int P = GAP + 1;
    localparam int CW = $clog2(ROUTE_LEN + 1);
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_en = 1'b0, clear = 1'b0, start = 1'b0, win = 1'b0, die = 1'b0;
    dir_type load_dir = D_NORTH;
    logic north, south, west, east, busy, done, full;
    result_type result;
    logic [CW-1:0] route_len, step_count;
    int n_tests = 0;
    int n_fail = 0;
    dir_type plan [10];
    dir_type route [$];
    adventure_player #(.ROUTE_LEN(ROUTE_LEN), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_dir(load_dir),
        .clear(clear), .start(start), .win(win), .die(die),
        .north(north), .south(south), .west(west), .east(east),
        .busy(busy), .done(done), .result(result), .route_len(route_len),
        .step_count(step_count), .full(full)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic logic [3:0] onehot(input dir_type d);
        return d == D_NORTH ? 4'b1000 : d == D_SOUTH ? 4'b0100 : d == D_WEST ? 4'b0010 : 4'b0001;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check_idle_outputs(input string tag, input int len);
        check({tag, "_pulses"}, {north, south, west, east}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_len"}, route_len, len);
    endtask
    // kind: bit0 raises win, bit1 raises die, both in cycle fc only
    task automatic run(input int n, input int fc, input int kind, input bit reload);
        int fin, exp_res, exp_steps, issued, len;
        logic [3:0] exp_p;
        if (reload) begin
            clear = 1'b1;
            step();
            clear = 1'b0;
            route.delete();
            @(negedge clk);
            check("clr_done", done, 0);
            check("clr_result", result, RES_NONE);
            check("clr_steps", step_count, 0);
            check("clr_len", route_len, 0);
            step();
            for (int i = 0; i < n; i++) begin
                load_en = 1'b1;
                load_dir = plan[i];
                if (route.size() < ROUTE_LEN) route.push_back(plan[i]);
                step();
            end
            load_en = 1'b0;
            @(negedge clk);
            check("load_len", route_len, route.size());
            check("load_full", full, route.size() == ROUTE_LEN);
            step();
        end
        len = route.size();
        fin = 1 + len * P;
        exp_res = RES_EXHAUSTED;
        exp_steps = len;
        if (kind != 0) begin
            for (int k = 0; k < len; k++) begin
                if (fc > 1 + k * P && fc <= 1 + k * P + GAP) begin
                    fin = fc + 1;
                    exp_res = kind[1] ? RES_DIE : RES_WIN;
                    exp_steps = k + 1;
                    break;
                end
            end
        end
        start = 1'b1;
        win = 1'($urandom_range(0, 1));
        die = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        issued = 0;
        for (int c = 1; c <= fin + 2; c++) begin
            win = (c == fc) ? kind[0] : (c >= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            die = (c == fc) ? kind[1] : (c >= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            load_en = c < fin ? 1'($urandom_range(0, 1)) : 1'b0;
            clear = c < fin ? 1'($urandom_range(0, 1)) : 1'b0;
            start = c < fin ? 1'($urandom_range(0, 1)) : 1'b0;
            load_dir = dir_type'($urandom_range(0, 3));
            @(negedge clk);
            exp_p = (c < fin && (c - 1) % P == 0) ? onehot(route[(c - 1) / P]) : 4'b0000;
            check("pulses", {north, south, west, east}, exp_p);
            check("busy", busy, c < fin);
            check("done", done, c >= fin);
            check("result", result, c >= fin ? exp_res : RES_NONE);
            check("steps", step_count, c >= fin ? exp_steps : issued);
            check("run_len", route_len, len);
            if (exp_p != 0) issued++;
            step();
        end
        {win, die, load_en, clear, start} = '0;
    endtask
    initial begin
        #2;
        check("rst_pulses", {north, south, west, east}, 0);
        check("rst_result", result, RES_NONE);
        check("rst_steps", step_count, 0);
        check("rst_full", full, 0);
        check_idle_outputs("rst", 0);
        step();
        reset = 1'b0;
        step();
        plan[0] = D_EAST; plan[1] = D_SOUTH; plan[2] = D_EAST;
        run(3, -1, 0, 1'b1);
        plan[0] = D_NORTH; plan[1] = D_NORTH; plan[2] = D_WEST;
        run(3, 4, 1, 1'b1);
        run(3, 2, 3, 1'b1);
        run(3, -1, 0, 1'b0);
        run(0, -1, 0, 1'b1);
        for (int i = 0; i < 10; i++) plan[i] = dir_type'($urandom_range(0, 3));
        run(10, -1, 0, 1'b1);
        clear = 1'b1;
        start = 1'b1;
        step();
        {clear, start} = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("clrstart", 0);
            step();
        end
        for (int r = 0; r < 30; r++) begin
            int n;
            n = $urandom_range(0, 10);
            for (int i = 0; i < 10; i++) plan[i] = dir_type'($urandom_range(0, 3));
            run(n, $urandom_range(1, 2 + (n > ROUTE_LEN ? ROUTE_LEN : n) * P), $urandom_range(0, 3), 1'b1);
        end
        plan[0] = D_WEST; plan[1] = D_SOUTH; plan[2] = D_NORTH;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_en = 1'b1;
            load_dir = plan[i];
            step();
        end
        load_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("arst_pulses", {north, south, west, east}, 0);
        check("arst_result", result, RES_NONE);
        check("arst_steps", step_count, 0);
        check("arst_full", full, 0);
        check_idle_outputs("arst", 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_outputs("post_rst", 0);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
